// File: rtl/cbfp0_pkg.sv
// Shared constants and state type for the CBFP stage-0 input controller.
package cbfp0_pkg;

    localparam int CBFP0_LANES     = 16;
    localparam int CBFP0_DW        = 23;
    localparam int CBFP0_FRAME_CYC = 32;
    localparam int CBFP0_GROUP_CYC = 4;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } cbfp0_in_state_t;

endpackage

// File: rtl/cbfp0_in_ctrl_if.sv
// Butterfly-to-CBFP0 bus: input samples plus alert/frame/delayed-data outputs.
// err_gap exists only when CBFP0_GAP_CHK_EN is defined.
interface cbfp0_in_ctrl_if
    import cbfp0_pkg::*;
#(
    parameter int LANES = CBFP0_LANES,
    parameter int DW    = CBFP0_DW,
    parameter int IW    = $clog2(CBFP0_FRAME_CYC / CBFP0_GROUP_CYC)
) ();

    logic                din_valid;
    logic [LANES*DW-1:0] din_re;
    logic [LANES*DW-1:0] din_im;
    logic                alert_cbfp;
    logic [IW-1:0]       grp_idx;
    logic                frame_done;
    logic                buf_valid;
    logic [LANES*DW-1:0] buf_re;
    logic [LANES*DW-1:0] buf_im;
`ifdef CBFP0_GAP_CHK_EN
    logic                err_gap;

    modport master (
        output din_valid, din_re, din_im,
        input  alert_cbfp, grp_idx, frame_done, buf_valid, buf_re, buf_im, err_gap
    );
    modport slave (
        input  din_valid, din_re, din_im,
        output alert_cbfp, grp_idx, frame_done, buf_valid, buf_re, buf_im, err_gap
    );
`else
    modport master (
        output din_valid, din_re, din_im,
        input  alert_cbfp, grp_idx, frame_done, buf_valid, buf_re, buf_im
    );
    modport slave (
        input  din_valid, din_re, din_im,
        output alert_cbfp, grp_idx, frame_done, buf_valid, buf_re, buf_im
    );
`endif

endinterface

// File: rtl/cbfp0_dly_line.sv
// Fixed-depth register shift line, WIDTH bits wide, cleared by async reset.
module cbfp0_dly_line #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    logic [WIDTH-1:0] stage_q [DEPTH];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) stage_q[i] <= '0;
        end else begin
            stage_q[0] <= din;
            for (int i = 1; i < DEPTH; i++) stage_q[i] <= stage_q[i-1];
        end
    end

    assign dout = stage_q[DEPTH-1];

endmodule

// File: rtl/cbfp0_in_ctrl.sv
// CBFP0 front end: per-frame valid-cycle counter, group alerts, frame_done and data delay.
// Optional mid-group gap detection is enabled by defining CBFP0_GAP_CHK_EN.
module cbfp0_in_ctrl
    import cbfp0_pkg::*;
#(
    parameter int LANES     = CBFP0_LANES,
    parameter int DW        = CBFP0_DW,
    parameter int FRAME_CYC = CBFP0_FRAME_CYC,
    parameter int GROUP_CYC = CBFP0_GROUP_CYC,
    parameter int BUF_DLY   = 6
) (
    input  logic         clk,
    input  logic         rst,
    cbfp0_in_ctrl_if.slave bus
);

    localparam int CW  = $clog2(FRAME_CYC);
    localparam int IW  = $clog2(FRAME_CYC / GROUP_CYC);
    localparam int GSH = $clog2(GROUP_CYC);
    localparam int LW  = 1 + 2 * LANES * DW;

    cbfp0_in_state_t state_q, state_nxt;
    logic [CW-1:0]   cnt_q, cnt_nxt;
    logic [IW-1:0]   grp_q, grp_nxt;
    logic            alert_q, alert_nxt;
    logic            done_q, done_nxt;
    logic            at_bound;
    logic            at_last;
    logic            mid_gap;
`ifdef CBFP0_GAP_CHK_EN
    logic            err_q, err_nxt;
`endif

    function automatic logic is_group_start(input logic [CW-1:0] c);
        return (c & CW'(GROUP_CYC - 1)) == '0;
    endfunction

    assign at_bound = is_group_start(cnt_q);
    assign at_last  = (cnt_q == CW'(FRAME_CYC - 1));
    assign mid_gap  = (state_q == RUN) && !bus.din_valid && !at_bound;

    always_comb begin
        state_nxt = state_q;
        cnt_nxt   = cnt_q;
        grp_nxt   = grp_q;
        alert_nxt = 1'b0;
        done_nxt  = 1'b0;
`ifdef CBFP0_GAP_CHK_EN
        err_nxt   = err_q;
`endif
        case (state_q)
            IDLE: if (bus.din_valid) state_nxt = RUN;
            RUN:  if (bus.din_valid && at_last) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase

        if (bus.din_valid) begin
            alert_nxt = at_bound;
            done_nxt  = at_last;
            cnt_nxt   = at_last ? '0 : cnt_q + CW'(1);
            if (at_bound) grp_nxt = IW'(cnt_q >> GSH);
        end
`ifdef CBFP0_GAP_CHK_EN
        // A gap inside a group breaks alignment: restart the frame at group 0.
        if (mid_gap) begin
            state_nxt = IDLE;
            cnt_nxt   = '0;
            err_nxt   = 1'b1;
        end
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            grp_q   <= '0;
            alert_q <= 1'b0;
            done_q  <= 1'b0;
`ifdef CBFP0_GAP_CHK_EN
            err_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_nxt;
            cnt_q   <= cnt_nxt;
            grp_q   <= grp_nxt;
            alert_q <= alert_nxt;
            done_q  <= done_nxt;
`ifdef CBFP0_GAP_CHK_EN
            err_q   <= err_nxt;
`endif
        end
    end

    assign bus.alert_cbfp = alert_q;
    assign bus.grp_idx    = grp_q;
    assign bus.frame_done = done_q;
`ifdef CBFP0_GAP_CHK_EN
    assign bus.err_gap    = err_q;
`else
    logic unused_mid_gap;
    assign unused_mid_gap = mid_gap;
`endif

    // Valid and data share one line so they stay aligned regardless of FSM state.
    logic [LW-1:0] dly_out;

    cbfp0_dly_line #(
        .WIDTH (LW),
        .DEPTH (BUF_DLY)
    ) u_dly (
        .clk  (clk),
        .rst  (rst),
        .din  ({bus.din_valid, bus.din_re, bus.din_im}),
        .dout (dly_out)
    );

    assign bus.buf_valid = dly_out[LW-1];
    assign bus.buf_re    = dly_out[LW-2 -: LANES*DW];
    assign bus.buf_im    = dly_out[LANES*DW-1:0];

endmodule

// File: tb/tb_cbfp0_in_ctrl.sv
// Directed bench for cbfp0_in_ctrl: table-driven frame vectors plus gap and reset sequences.
module tb_cbfp0_in_ctrl;
    import cbfp0_pkg::*;

    localparam int LANES   = 16;
    localparam int DW      = 23;
    localparam int IW      = 3;
    localparam int BUF_DLY = 6;
    localparam int N       = LANES * DW;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    cbfp0_in_ctrl_if #(.LANES(LANES), .DW(DW), .IW(IW)) bus ();

    cbfp0_in_ctrl #(
        .LANES(LANES), .DW(DW), .FRAME_CYC(32), .GROUP_CYC(4), .BUF_DLY(BUF_DLY)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic v;
        logic ea;
        int   eg;
        logic ed;
    } vec_t;

    typedef struct {
        logic         v;
        logic [N-1:0] re;
        logic [N-1:0] im;
    } hist_t;

    vec_t  tbl[$];
    hist_t hq[$];
    int    n_chk  = 0;
    int    n_fail = 0;
    int    exp_grp = 0;
    logic  exp_err = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    task automatic chk_w(input string name, input logic [N-1:0] act, input logic [N-1:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    task automatic hist_reset();
        hist_t z;
        z.v = 1'b0; z.re = '0; z.im = '0;
        hq.delete();
        for (int i = 0; i < BUF_DLY; i++) hq.push_back(z);
    endtask

    task automatic add_valid(input int from, input int to);
        vec_t e;
        for (int k = from; k <= to; k++) begin
            if (k % 4 == 0) exp_grp = k / 4;
            e.v = 1'b1; e.ea = (k % 4 == 0); e.eg = exp_grp; e.ed = (k == 31);
            tbl.push_back(e);
        end
    endtask

    task automatic add_gap(input int n);
        vec_t e;
        for (int i = 0; i < n; i++) begin
            e.v = 1'b0; e.ea = 1'b0; e.eg = exp_grp; e.ed = 1'b0;
            tbl.push_back(e);
        end
    endtask

    // Drive one cycle at the falling edge, check registered results just after the rising edge.
    task automatic tick(input vec_t e);
        hist_t h;
        @(negedge clk);
        h.v = e.v;
        for (int l = 0; l < LANES; l++) begin
            h.re[l*DW +: DW] = DW'($urandom);
            h.im[l*DW +: DW] = DW'($urandom);
        end
        bus.din_valid = h.v;
        bus.din_re    = h.re;
        bus.din_im    = h.im;
        hq.push_back(h);
        @(posedge clk);
        #1;
        chk("alert_cbfp", 64'(bus.alert_cbfp), 64'(e.ea));
        chk("grp_idx",    64'(bus.grp_idx),    64'(e.eg));
        chk("frame_done", 64'(bus.frame_done), 64'(e.ed));
`ifdef CBFP0_GAP_CHK_EN
        chk("err_gap",    64'(bus.err_gap),    64'(exp_err));
`endif
        h = hq[hq.size() - BUF_DLY];
        chk("buf_valid", 64'(bus.buf_valid), 64'(h.v));
        chk_w("buf_re", bus.buf_re, h.re);
        chk_w("buf_im", bus.buf_im, h.im);
        void'(hq.pop_front());
    endtask

    task automatic run_tbl();
        for (int i = 0; i < tbl.size(); i++) tick(tbl[i]);
        tbl.delete();
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, ":alert_cbfp"}, 64'(bus.alert_cbfp), 64'd0);
        chk({tag, ":grp_idx"},    64'(bus.grp_idx),    64'd0);
        chk({tag, ":frame_done"}, 64'(bus.frame_done), 64'd0);
        chk({tag, ":buf_valid"},  64'(bus.buf_valid),  64'd0);
        chk_w({tag, ":buf_re"},   bus.buf_re, '0);
        chk_w({tag, ":buf_im"},   bus.buf_im, '0);
`ifdef CBFP0_GAP_CHK_EN
        chk({tag, ":err_gap"},    64'(bus.err_gap),    64'd0);
`endif
    endtask

    // Assert reset asynchronously, hold it, release it mid-high-phase so no edge clocks stale inputs.
    task automatic do_reset(input int cycles);
        @(negedge clk);
        bus.din_valid = 1'b0;
        rst = 1'b1;
        #1;
        chk_all_zero("rst_now");
        repeat (cycles) @(posedge clk);
        #1;
        chk_all_zero("rst_hold");
        #1;
        rst = 1'b0;
        hist_reset();
        exp_grp = 0;
        exp_err = 1'b0;
    endtask

    initial begin
        bus.din_valid = 1'b0;
        bus.din_re    = '0;
        bus.din_im    = '0;
        do_reset(2);

        // Single frame then a back-to-back frame; grp_idx wraps 7 -> 0.
        add_valid(0, 31);
        add_valid(0, 31);
        // Gap of 3 at the group boundary after valid cycle 8.
        add_valid(0, 7);
        add_gap(3);
        add_valid(8, 31);
        add_gap(2);
        run_tbl();

        // Mid-group gap after valid cycle 6.
        add_valid(0, 5);
        run_tbl();
`ifdef CBFP0_GAP_CHK_EN
        exp_err = 1'b1;
        add_gap(2);
        run_tbl();
        add_valid(0, 31);
        add_gap(1);
        run_tbl();
`else
        add_gap(2);
        add_valid(6, 31);
        add_gap(1);
        run_tbl();
`endif

        // Reset after 17 valid cycles; the partial frame is discarded.
        add_valid(0, 16);
        run_tbl();
        do_reset(2);
        add_valid(0, 31);
        add_gap(8);
        run_tbl();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
